combo_input_ctrl: RTL and testbench
===================================

COMBO_INPUT_CTRL -- requirements
Module: combo_input_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16, consecutive stable clocks required before a button level is accepted (minimum 1).
REQ-002 Parameter: RESET_COMBO, 4'b0110, stored combination loaded on reset.
REQ-003 Port: Clock  in  1  system clock; all state updates on its rising edge.
REQ-004 Port: Reset  in  1  asynchronous, active-high reset.
REQ-005 Port: enter_btn  in  1  raw active-low push button; 0 = pressed; asynchronous to Clock.
REQ-006 Port: change_btn  in  1  raw active-low push button; 0 = pressed; asynchronous to Clock.
REQ-007 Port: sw  in  4  raw switch inputs carrying the candidate combination; asynchronous.
REQ-008 Port: set  in  1  store request from the lock FSM; high while the FSM is in its store state.
REQ-009 Port: enter  out  1  single-cycle pulse per debounced press of enter_btn.
REQ-010 Port: change  out  1  single-cycle pulse per debounced press of change_btn.
REQ-011 Port: isCombo  out  1  registered flag; 1 when the synchronized switches equal the stored combination.
REQ-012 Port: combo  out  4  currently stored combination.

Function
REQ-013 Each button input SHALL pass through a 2-flop synchronizer reset to 1 (released).
REQ-014 Each button SHALL have an independent debounce counter, width ceil(log2(DEBOUNCE_CYCLES+1)), cleared on any clock where the synchronized level equals the debounced level.
REQ-015 The counter SHALL increment while synchronized level differs from debounced level; on reaching DEBOUNCE_CYCLES the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-016 A bounce back to the debounced level before DEBOUNCE_CYCLES SHALL clear the counter with no level change.
REQ-017 enter/change SHALL be high for exactly one cycle following each released->pressed transition of the debounced level; no pulse on release; a held press produces one pulse only.
REQ-018 Latency: with the raw press stable, the pulse SHALL be high during the cycle after rising edge DEBOUNCE_CYCLES+3, counting the first edge sampling the raw pressed level as edge 1.
REQ-019 Simultaneous debounced presses of both buttons SHALL produce both pulses in the same cycle; arbitration is left to the lock FSM.
REQ-020 sw SHALL pass through a 2-flop synchronizer only (no debounce), giving sw_s.
REQ-021 isCombo SHALL be registered as (sw_s == combo); a change on sw appears on isCombo after 3 rising edges.
REQ-022 A 1-flop delayed copy of set SHALL be kept; on a cycle where set=1 and the delayed copy=0, combo SHALL load sw_s at the next edge.
REQ-023 set held high for multiple cycles SHALL store exactly once; switch changes while set stays high SHALL NOT update combo.
REQ-024 The isCombo compare on the edge that loads combo SHALL use the old combo; from the following edge, the new combo.
REQ-025 set rising in the same cycle as an sw_s change SHALL store the sw_s value present in that cycle.

Reset
REQ-026 On Reset=1, immediately and independent of Clock: combo=RESET_COMBO, enter=0, change=0, isCombo=0, button synchronizers and debounced levels=released, counters=0, sw synchronizer=4'b0000, set delay flop=0.
REQ-027 Reset asserted mid-debounce or mid-store SHALL abandon the operation; no pulse and no store SHALL occur afterwards as a consequence.
REQ-028 After Reset deasserts, a button already held SHALL be treated as a new press and pulse once after the REQ-018 latency.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset, sw=4'b0110 -> combo=0110 and isCombo=1 after 3 edges; sw=4'b0111 -> isCombo=0 after 3 edges.
REQ-030 enter_btn low for 20 cycles -> enter high exactly one cycle, after edge 7; change stays 0; no pulse on release.
REQ-031 enter_btn low 3 cycles, high 2 cycles, low 3 cycles -> no pulse.
REQ-032 sw=4'b1010, set high 5 cycles, sw changed to 4'b0001 during cycle 3 -> combo=1010 (single store); isCombo=1 for sw=1010 and 0 for sw=0001.
REQ-033 Both buttons low simultaneously for 10 cycles -> enter and change both pulse in the same single cycle.
REQ-034 change_btn low, Reset pulsed at edge 4 while button stays low -> no pulse before reset; one change pulse after edge 7 counted from reset release; combo=0110.

Source files
------------

// File: rtl/combo_input_ctrl.sv
// rtl/combo_input_ctrl.sv - button synchronize/debounce/edge pulse and combination store/compare
// Buttons are active-low; the debounced level idles high (released) and a press pulses once.
module combo_input_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [3:0]  RESET_COMBO     = 4'b0110
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       enter_btn,
  input  logic       change_btn,
  input  logic [3:0] sw,
  input  logic       set,
  output logic       enter,
  output logic       change,
  output logic       isCombo,
  output logic [3:0] combo
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       raw_btn;
  logic [1:0]       bsync1_q, bsync2_q;
  logic [1:0]       db_q, db_d;
  logic [1:0]       pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic [3:0] sw_s1_q, sw_s_q;
  logic [3:0] combo_q, combo_d;
  logic       is_combo_q;
  logic       set_q;

  assign raw_btn = {change_btn, enter_btn};

  // Index 0 is enter, index 1 is change; pulse fires only on the released->pressed flip.
  always_comb begin
    db_d    = db_q;
    pulse_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bsync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]    = bsync2_q[i];
        cnt_d[i]   = '0;
        pulse_d[i] = db_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    combo_d = combo_q;
    if (set && !set_q) begin
      combo_d = sw_s_q;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bsync1_q   <= 2'b11;
      bsync2_q   <= 2'b11;
      db_q       <= 2'b11;
      pulse_q    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
      sw_s1_q    <= 4'b0000;
      sw_s_q     <= 4'b0000;
      combo_q    <= RESET_COMBO;
      is_combo_q <= 1'b0;
      set_q      <= 1'b0;
    end else begin
      bsync1_q   <= raw_btn;
      bsync2_q   <= bsync1_q;
      db_q       <= db_d;
      pulse_q    <= pulse_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sw_s1_q    <= sw;
      sw_s_q     <= sw_s1_q;
      combo_q    <= combo_d;
      is_combo_q <= (sw_s_q == combo_q);
      set_q      <= set;
    end
  end

  assign enter   = pulse_q[0];
  assign change  = pulse_q[1];
  assign isCombo = is_combo_q;
  assign combo   = combo_q;

endmodule

// File: tb/tb_combo_input_ctrl.sv
// tb/tb_combo_input_ctrl.sv - scoreboard bench for combo_input_ctrl
module tb_combo_input_ctrl;

  localparam int D = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       enter_btn = 1'b1;
  logic       change_btn = 1'b1;
  logic [3:0] sw = 4'b0000;
  logic       set = 1'b0;
  logic       enter, change, isCombo;
  logic [3:0] combo;

  typedef struct packed {
    logic       enter;
    logic       change;
    logic       is_combo;
    logic [3:0] combo;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs, exp_v;
  int   n_cmp = 0;
  int   n_err = 0;

  assign obs = {enter, change, isCombo, combo};

  combo_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .RESET_COMBO    (4'b0110)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .enter_btn (enter_btn),
    .change_btn(change_btn),
    .sw        (sw),
    .set       (set),
    .enter     (enter),
    .change    (change),
    .isCombo   (isCombo),
    .combo     (combo)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    #2 Reset = 1'b1;
    #1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 4'b0110});
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL reset_async got %b want %b", obs, exp_v);
    end
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back({1'b0, 1'b0, 1'b0, 4'b0110});
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_held edge %0d got %b want %b", k, obs, exp_v);
      end
    end
    Reset = 1'b0;
  endtask

  task automatic test_iscombo();
    sw = 4'b0110;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back({1'b0, 1'b0, (k >= 3), 4'b0110});
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL iscombo_match edge %0d got %b want %b", k, obs, exp_v);
      end
    end
    sw = 4'b0111;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back({1'b0, 1'b0, (k < 3), 4'b0110});
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL iscombo_miss edge %0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_enter_press();
    for (int k = 1; k <= 40; k++) begin
      enter_btn = (k <= 20) ? 1'b0 : 1'b1;
      exp_q.push_back({(k == D + 3), 1'b0, 1'b0, 4'b0110});
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL enter_press cycle %0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    for (int k = 1; k <= 16; k++) begin
      enter_btn = ((k >= 1 && k <= 3) || (k >= 6 && k <= 8)) ? 1'b0 : 1'b1;
      exp_q.push_back({1'b0, 1'b0, 1'b0, 4'b0110});
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL bounce cycle %0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 40; k++) begin
      enter_btn = (k <= 10 || (k > 20 && k <= 30)) ? 1'b0 : 1'b1;
      exp_q.push_back({(k == D + 3 || k == 20 + D + 3), 1'b0, 1'b0, 4'b0110});
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL back_to_back cycle %0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_both_buttons();
    for (int k = 1; k <= 22; k++) begin
      enter_btn  = (k <= 10) ? 1'b0 : 1'b1;
      change_btn = (k <= 10) ? 1'b0 : 1'b1;
      exp_q.push_back({(k == D + 3), (k == D + 3), 1'b0, 4'b0110});
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL both_buttons cycle %0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_set_store();
    sw = 4'b1010;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back({1'b0, 1'b0, 1'b0, 4'b0110});
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL store_setup edge %0d got %b want %b", k, obs, exp_v);
      end
    end
    // Store happens on the first set edge; the sw change in cycle 3 must not be stored.
    for (int c = 1; c <= 8; c++) begin
      set = (c <= 5);
      if (c >= 3) sw = 4'b0001;
      exp_q.push_back({1'b0, 1'b0, (c >= 2 && c <= 4), 4'b1010});
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL set_store cycle %0d got %b want %b", c, obs, exp_v);
      end
    end
    sw = 4'b1010;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back({1'b0, 1'b0, (k == 3), 4'b1010});
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL store_recheck edge %0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    change_btn = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back({1'b0, 1'b0, 1'b1, 4'b1010});
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL pre_reset edge %0d got %b want %b", k, obs, exp_v);
      end
    end
    Reset = 1'b1;
    #1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 4'b0110});
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL mid_reset_async got %b want %b", obs, exp_v);
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 4'b0110});
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL mid_reset_held got %b want %b", obs, exp_v);
    end
    Reset = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      change_btn = (k <= 12) ? 1'b0 : 1'b1;
      exp_q.push_back({1'b0, (k == D + 3), 1'b0, 4'b0110});
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL post_reset_press cycle %0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_iscombo();
    test_enter_press();
    test_bounce();
    test_back_to_back();
    test_both_buttons();
    test_set_store();
    test_reset_mid_debounce();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
